sort4_controller: RTL and testbench
===================================

// Module: sort4_controller
// PURPOSE
//   Sequential bubble-sort controller that sorts N signed W-bit values ascending.
//   Time-shares one compare unit: exactly one compare per clock, with a conditional swap.
//   Sits between the switch/register input stage and the display/output stage of the lab datapath.
//   Ordering is by two's-complement value, so a subtract-with-overflow compare is used (less = V ^ S[msb]).
// PARAMETERS
//   N  4  number of elements to sort (>=2)
//   W  4  element width in bits, signed two's complement
// PORTS
//   clk       in   1                     rising-edge clock
//   rst_n     in   1                     asynchronous active-low reset
//   start     in   1                     request a sort; sampled only in IDLE
//   din       in   N*W                   element k = din[k*W +: W]
//   busy      out  1                     high in SORT and DONE states
//   done      out  1                     one-cycle pulse: dout is valid and updated
//   dout      out  N*W                   sorted result; element 0 is the smallest
//   swap_cnt  out  $clog2(N*N)+1         swaps performed in the last sort
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low.
//   Reset: state=IDLE; r[*]=0; dout=0; done=0; busy=0; swap_cnt=0; i=0; swapped=0.
//   FSM states: IDLE, SORT, DONE.
//   IDLE: on start=1 at a clock edge:
//     - r[k] <= din[k]; i <= 0; swapped <= 0; swap_cnt <= 0
//     - next state SORT
//   SORT: each cycle compares r[i] (A) with r[i+1] (B) using signed compare.
//     - If A > B (X=1): swap r[i] and r[i+1] at the edge; swap_cnt += 1; swapped <= 1.
//     - If A == B or A < B: no swap. Equal elements are never swapped, so the sort is stable.
//     - If i < N-2: i <= i+1.
//     - If i == N-2 and (swapped or a swap occurred this cycle): i <= 0; swapped <= 0; begin a new pass.
//     - If i == N-2 and no swap occurred in the whole pass: next state DONE.
//   DONE: dout <= r (registered); done=1 for exactly this one cycle; next state IDLE.
//   Latency, start edge to done high:
//     - (passes * (N-1)) + 1 cycles.
//     - Already-sorted input: N cycles.
//     - Fully reversed input with N=4: 13 cycles.
//   start while busy: ignored. No queuing; din is sampled only at the accepting edge.
//   start held high across DONE: a new sort is accepted on the first IDLE cycle.
//   din changing during SORT: no effect.
//   dout and swap_cnt hold their value until the next DONE state.
//   Before the first DONE, swap_cnt shows the running count of the sort in progress.
//   Reset mid-sort: abort immediately; all outputs return to reset values; no done pulse.
//   Compare arithmetic:
//     - S = A - B, computed as A + ~B + 1 at W bits.
//     - less = V ^ S[W-1]; equal = (S == 0); greater = ~(less | equal).
//     - Overflow is handled by V, e.g. A=7, B=-8 gives greater=1.
// STRUCTURE
//   Package sort_pkg holds:
//     - state encoding localparams ST_IDLE=2'd0, ST_SORT=2'd1, ST_DONE=2'd2
//     - default N and W
//     - function for the swap_cnt width
//   Sub-module: signed_cmp #(W) (a, b -> eq, gt, lt).
//     - Built on the existing W-bit adder/subtractor with mode=1 (subtract).
//     - Instantiated exactly once; index muxes select r[i] and r[i+1].
//   Top-level holds: the element register array, the FSM, the pass/index counters and swap_cnt.
// TESTING
//   1. Reset with start=1, din random -> busy=0, done=0, dout=0 until rst_n goes high.
//   2. din={3,2,1,0} as elements 0..3 ascending (already sorted) ->
//      done at start+4 cycles, dout unchanged, swap_cnt=0.
//   3. din elements {3,2,1,0} (reversed) -> done at start+13 cycles, dout={0,1,2,3}, swap_cnt=6.
//   4. Signed/overflow: elements {7,-8,0,-1} -> dout={-8,-1,0,7} (4'h8,4'hF,4'h0,4'h7).
//   5. Duplicates {5,5,-3,5} -> dout={-3,5,5,5}, swap_cnt=2, no swaps counted between equal values.
//   6. Robustness:
//      - Pulse start in SORT: ignored, result unchanged.
//      - Drop rst_n mid-sort: no done pulse, outputs return to 0.
//      - Re-sort after reset: correct result.

Source files
------------

// File: rtl/sort4_controller_pkg.sv
// Shared state encoding, default geometry and width helper for the bubble-sort controller.
package sort_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SORT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SORT = ST_SORT,
        DONE = ST_DONE
    } state_t;

    localparam int N_DEF = 4;
    localparam int W_DEF = 4;

    function automatic int cnt_width(input int n);
        return $clog2(n * n) + 1;
    endfunction

endpackage

// File: rtl/sort4_controller_signed_cmp.sv
// Two's-complement magnitude compare built on a W-bit adder/subtractor in subtract mode.
module signed_cmp #(
    parameter int W = 4
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic                eq,
    output logic                gt,
    output logic                lt
);

    localparam logic MODE = 1'b1;

    logic [W-1:0] b_op;
    logic [W-1:0] s;
    logic         v;

    // a - b as a + ~b + 1; v flags signed overflow of that addition
    assign b_op = b ^ {W{MODE}};
    assign s    = a + b_op + W'(MODE);
    assign v    = (a[W-1] == b_op[W-1]) && (s[W-1] != a[W-1]);

    assign lt = v ^ s[W-1];
    assign eq = (s == '0);
    assign gt = ~(lt | eq);

endmodule

// File: rtl/sort4_controller.sv
// Sequential bubble sort of N signed W-bit elements, one compare-and-swap per clock.
module sort4_controller
    import sort_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [N*W-1:0]            din,
    output logic                      busy,
    output logic                      done,
    output logic [N*W-1:0]            dout,
    output logic [cnt_width(N)-1:0]   swap_cnt
);

    localparam int CW = cnt_width(N);
    localparam int IW = $clog2(N);

    state_t               state;
    state_t               state_nxt;
    logic signed [W-1:0]  r [N];
    logic [IW-1:0]        i;
    logic [IW-1:0]        i_nxt;
    logic                 swapped;
    logic                 last;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_held;
    logic                 held;
    logic signed [W-1:0]  a;
    logic signed [W-1:0]  b;
    logic                 cmp_eq;
    logic                 cmp_gt;
    logic                 cmp_lt;
    logic                 do_swap;

    assign i_nxt = i + IW'(1);
    assign last  = (i == IW'(N - 2));
    assign a     = r[i];
    assign b     = r[i_nxt];

    signed_cmp #(.W(W)) u_cmp (
        .a  (a),
        .b  (b),
        .eq (cmp_eq),
        .gt (cmp_gt),
        .lt (cmp_lt)
    );

    // Only a strict greater-than swaps, so equal elements keep their order
    assign do_swap = cmp_gt & ~cmp_lt & ~cmp_eq;

    // Once a result exists, the reported count is frozen until the next DONE
    assign swap_cnt = held ? cnt_held : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = SORT;
            SORT: begin
                busy = 1'b1;
                if (last && !swapped && !do_swap) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) r[k] <= '0;
            i        <= '0;
            swapped  <= 1'b0;
            cnt      <= '0;
            cnt_held <= '0;
            held     <= 1'b0;
            dout     <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    for (int k = 0; k < N; k++) r[k] <= din[k*W +: W];
                    i       <= '0;
                    swapped <= 1'b0;
                    cnt     <= '0;
                end
                SORT: begin
                    if (do_swap) begin
                        r[i]     <= b;
                        r[i_nxt] <= a;
                        cnt      <= cnt + CW'(1);
                    end
                    if (!last) begin
                        i <= i_nxt;
                        if (do_swap) swapped <= 1'b1;
                    end else begin
                        i       <= '0;
                        swapped <= 1'b0;
                    end
                end
                DONE: begin
                    for (int k = 0; k < N; k++) dout[k*W +: W] <= r[k];
                    done     <= 1'b1;
                    cnt_held <= cnt;
                    held     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort4_controller.sv
// Directed table-driven bench for sort4_controller (N=4, W=4) plus multi-cycle corner sequences.
module tb_sort4_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic [4:0]  swap_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sort4_controller #(.N(4), .W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .dout     (dout),
        .swap_cnt (swap_cnt)
    );

    typedef struct {
        logic [15:0] din;
        logic [15:0] exp_dout;
        int          exp_swaps;
        int          exp_lat;
        bit          glitch;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [15:0] pk(input int e0, input int e1, input int e2, input int e3);
        return {4'(e3), 4'(e2), 4'(e1), 4'(e0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_sort(input logic [15:0] d, input bit glitch, output int lat);
        int w;
        @(negedge clk);
        din   = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        din   = 16'($urandom);
        if (glitch) begin
            repeat (2) @(posedge clk);
            #1;
            start = 1'b1;
            din   = pk(1, 1, 1, 1);
            @(posedge clk); #1;
            start = 1'b0;
            wait_done(w);
            lat = (w < 0) ? -1 : w + 3;
        end else begin
            wait_done(lat);
        end
    endtask

    initial begin
        int lat;
        int w;

        vecs[0] = '{pk(0, 1, 2, 3),    pk(0, 1, 2, 3),    0, 4,  1'b0};
        vecs[1] = '{pk(7, -8, 0, -1),  pk(-8, -1, 0, 7),  4, 10, 1'b0};
        vecs[2] = '{pk(5, 5, -3, 5),   pk(-3, 5, 5, 5),   2, 10, 1'b0};
        vecs[3] = '{pk(-1, -1, -1, -1), pk(-1, -1, -1, -1), 0, 4, 1'b0};
        vecs[4] = '{pk(0, -8, 7, -8),  pk(-8, -8, 0, 7),  3, 10, 1'b0};
        vecs[5] = '{pk(3, 2, 1, 0),    pk(0, 1, 2, 3),    6, 13, 1'b1};

        // Reset held with start asserted and random data
        rst_n = 1'b0;
        start = 1'b1;
        din   = 16'($urandom);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_dout", dout, 0);
            chk("rst_swap_cnt", swap_cnt, 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        // Running count mid-sort, then abort by reset
        @(negedge clk);
        din   = pk(3, 2, 1, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("running_swap_cnt", swap_cnt, 2);
        chk("running_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_swap_cnt", swap_cnt, 0);
        chk("abort_dout", dout, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort_no_done", done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table of sorts; the first entry is the re-sort after reset
        for (int v = 0; v < 6; v++) begin
            run_sort(vecs[v].din, vecs[v].glitch, lat);
            chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            chk($sformatf("v%0d_dout", v), dout, vecs[v].exp_dout);
            chk($sformatf("v%0d_swap_cnt", v), swap_cnt, 32'(vecs[v].exp_swaps));
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_one_cycle", v), done, 0);
            chk($sformatf("v%0d_idle_busy", v), busy, 0);
        end

        // Previous result holds while a new sort runs
        @(negedge clk);
        din   = pk(7, -8, 0, -1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_swap_cnt", swap_cnt, 6);
        chk("hold_dout", dout, pk(0, 1, 2, 3));
        wait_done(w);
        chk("hold_latency", 32'((w < 0) ? -1 : w + 3), 10);
        chk("hold_new_dout", dout, pk(-8, -1, 0, 7));
        chk("hold_new_swap_cnt", swap_cnt, 4);

        // Start held high across DONE restarts on the first IDLE cycle
        @(negedge clk);
        din   = pk(2, 2, 3, 4);
        start = 1'b1;
        @(posedge clk); #1;
        wait_done(w);
        chk("held_start_latency", 32'(w), 4);
        chk("held_start_dout", dout, pk(2, 2, 3, 4));
        @(posedge clk); #1;
        chk("held_start_restart_busy", busy, 1);
        start = 1'b0;
        wait_done(w);
        chk("held_start_second_latency", 32'(w), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
